// File: rtl/cond_flag_unit.sv
// Execute-stage ARM condition unit: NZCV flag register, condition evaluation,
// control annulment, Execute/Memory boundary register and debug counters.
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [3:0]       cond_i,
   input  logic [1:0]       flag_write_i,
   input  logic [3:0]       alu_flags_i,
   input  logic             reg_write_i,
   input  logic             mem_write_i,
   input  logic             pc_src_i,
   output logic             cond_ex_o,
   output logic             reg_write_o,
   output logic             mem_write_o,
   output logic             pc_src_o,
   output logic [3:0]       flags_o,
   output logic             valid_q,
   output logic             reg_write_q,
   output logic             mem_write_q,
   output logic             pc_src_q,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] exec_cnt_o,
   output logic [CNT_W-1:0] annul_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [3:0]       flags_q, flags_d;
   logic             valid_d, reg_write_d, mem_write_d, pc_src_d;
   logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
   logic [CNT_W-1:0] annul_cnt_q, annul_cnt_d;
   logic             flag_n, flag_z, flag_c, flag_v;
   logic             cond_pass;
   logic             accept;

   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

   always_comb begin
      cond_pass = 1'b0;
      case (cond_i)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign cond_ex_o   = valid_i & cond_pass;
   assign reg_write_o = reg_write_i & cond_ex_o;
   assign mem_write_o = mem_write_i & cond_ex_o;
   assign pc_src_o    = pc_src_i & cond_ex_o;
   assign accept      = valid_i & ~stall_i & ~flush_i;
   assign flags_o     = flags_q;
   assign exec_cnt_o  = exec_cnt_q;
   assign annul_cnt_o = annul_cnt_q;

   // Flags are written only by instructions that actually retire from Execute.
   always_comb begin
      flags_d = flags_q;
      if (accept && cond_ex_o) begin
         if (flag_write_i[1]) flags_d[3:2] = alu_flags_i[3:2];
         if (flag_write_i[0]) flags_d[1:0] = alu_flags_i[1:0];
      end
   end

   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      mem_write_d = mem_write_q;
      pc_src_d    = pc_src_q;
      if (flush_i) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         mem_write_d = 1'b0;
         pc_src_d    = 1'b0;
      end else if (!stall_i) begin
         valid_d     = valid_i;
         reg_write_d = reg_write_o;
         mem_write_d = mem_write_o;
         pc_src_d    = pc_src_o;
      end
   end

   always_comb begin
      exec_cnt_d  = exec_cnt_q;
      annul_cnt_d = annul_cnt_q;
      if (cnt_clr_i) begin
         exec_cnt_d  = '0;
         annul_cnt_d = '0;
      end else if (accept) begin
         if (cond_ex_o) begin
            if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_W'(1);
         end else begin
            if (annul_cnt_q != CNT_MAX) annul_cnt_d = annul_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q     <= '0;
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_write_q <= 1'b0;
         pc_src_q    <= 1'b0;
         exec_cnt_q  <= '0;
         annul_cnt_q <= '0;
      end else begin
         flags_q     <= flags_d;
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         mem_write_q <= mem_write_d;
         pc_src_q    <= pc_src_d;
         exec_cnt_q  <= exec_cnt_d;
         annul_cnt_q <= annul_cnt_d;
      end
   end

endmodule
